// File: rtl/simon_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : simon_sequencer
// Brief    : Simon Says game controller: random colour sequence, LED playback,
//            player entry checking, fail/win reporting.
// Revision : 1.0
// ============================================================================
module simon_sequencer #(
    parameter int          MAX_LEN       = 16,
    parameter int          ON_TICKS      = 12500000,
    parameter int          OFF_TICKS     = 6250000,
    parameter int          TIMEOUT_TICKS = 125000000,
    parameter logic [15:0] SEED          = 16'hACE1
) (
    input  logic       clk_d,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] btn,
    output logic [3:0] led,
    output logic [5:0] level,
    output logic       busy,
    output logic       game_over,
    output logic       win
);

    localparam int c_AW     = $clog2(MAX_LEN);
    localparam int c_IW     = $clog2(MAX_LEN) + 1;
    localparam int c_MAX_T1 = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int c_MAX_T  = (TIMEOUT_TICKS > c_MAX_T1) ? TIMEOUT_TICKS : c_MAX_T1;
    localparam int c_TW     = $clog2(c_MAX_T + 1);

    localparam logic [c_TW-1:0] c_ON_LAST  = c_TW'(ON_TICKS - 1);
    localparam logic [c_TW-1:0] c_OFF_LAST = c_TW'(OFF_TICKS - 1);
    localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(TIMEOUT_TICKS - 1);
    localparam logic [5:0]      c_MAX_LVL  = 6'(MAX_LEN);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_GEN      = 4'd1,
        S_PRE      = 4'd2,
        S_SHOW_ON  = 4'd3,
        S_SHOW_OFF = 4'd4,
        S_WAIT_IN  = 4'd5,
        S_ECHO     = 4'd6,
        S_FAIL     = 4'd7,
        S_WIN      = 4'd8
    } state_t;

    state_t            r_state;
    logic [15:0]       r_lfsr;
    logic [c_TW-1:0]   r_tick;
    logic [c_IW-1:0]   r_idx;
    logic [1:0]        r_mem [0:(1<<c_AW)-1];

    logic              w_restart;
    logic              w_more;
    logic [c_AW-1:0]   w_idx_inc;
    logic [3:0]        w_cur;
    logic [3:0]        w_nxt;

    function automatic logic [3:0] onehot(input logic [1:0] c);
        return 4'b0001 << c;
    endfunction

    assign w_restart = start && (r_state == S_IDLE || r_state == S_FAIL || r_state == S_WIN);
    assign w_more    = (6'(r_idx) + 6'd1) < level;
    assign w_idx_inc = r_idx[c_AW-1:0] + c_AW'(1);
    assign w_cur     = onehot(r_mem[r_idx[c_AW-1:0]]);
    assign w_nxt     = onehot(r_mem[w_idx_inc]);

    // x^16 + x^14 + x^13 + x^11 + 1, free-running from reset
    always_ff @(posedge clk_d or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
        end
    end

    always_ff @(posedge clk_d) begin
        if (r_state == S_GEN) begin
            r_mem[level[c_AW-1:0]] <= r_lfsr[1:0];
        end
    end

    // Outputs are loaded on each transition so they are valid from a state's first cycle
    always_ff @(posedge clk_d or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_tick    <= '0;
            r_idx     <= '0;
            led       <= 4'h0;
            level     <= 6'd0;
            busy      <= 1'b0;
            game_over <= 1'b0;
            win       <= 1'b0;
        end else if (w_restart) begin
            r_state   <= S_GEN;
            r_tick    <= '0;
            led       <= 4'h0;
            level     <= 6'd0;
            busy      <= 1'b1;
            game_over <= 1'b0;
            win       <= 1'b0;
        end else begin
            r_tick <= r_tick + c_TW'(1);
            case (r_state)
                S_IDLE, S_FAIL: begin
                    r_tick <= '0;
                end
                S_GEN: begin
                    level   <= level + 6'd1;
                    r_idx   <= '0;
                    r_tick  <= '0;
                    r_state <= S_PRE;
                end
                S_PRE: begin
                    if (r_tick == c_OFF_LAST) begin
                        r_tick  <= '0;
                        led     <= w_cur;
                        r_state <= S_SHOW_ON;
                    end
                end
                S_SHOW_ON: begin
                    if (r_tick == c_ON_LAST) begin
                        r_tick  <= '0;
                        led     <= 4'h0;
                        r_state <= S_SHOW_OFF;
                    end
                end
                S_SHOW_OFF: begin
                    if (r_tick == c_OFF_LAST) begin
                        r_tick <= '0;
                        if (w_more) begin
                            r_idx   <= r_idx + c_IW'(1);
                            led     <= w_nxt;
                            r_state <= S_SHOW_ON;
                        end else begin
                            r_idx   <= '0;
                            r_state <= S_WAIT_IN;
                        end
                    end
                end
                S_WAIT_IN: begin
                    if (btn == w_cur) begin
                        r_tick  <= '0;
                        led     <= btn;
                        r_state <= S_ECHO;
                    end else if (btn != 4'h0 || r_tick == c_TMO_LAST) begin
                        r_tick    <= '0;
                        led       <= 4'hF;
                        busy      <= 1'b0;
                        game_over <= 1'b1;
                        r_state   <= S_FAIL;
                    end
                end
                S_ECHO: begin
                    if (r_tick == c_ON_LAST) begin
                        r_tick <= '0;
                        led    <= 4'h0;
                        if (w_more) begin
                            r_idx   <= r_idx + c_IW'(1);
                            r_state <= S_WAIT_IN;
                        end else if (level == c_MAX_LVL) begin
                            led     <= 4'b0101;
                            busy    <= 1'b0;
                            win     <= 1'b1;
                            r_state <= S_WIN;
                        end else begin
                            r_state <= S_GEN;
                        end
                    end
                end
                S_WIN: begin
                    if (r_tick == c_ON_LAST) begin
                        r_tick <= '0;
                        led    <= ~led;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_tick    <= '0;
                    led       <= 4'h0;
                    busy      <= 1'b0;
                    game_over <= 1'b0;
                    win       <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_simon_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_simon_sequencer
// Brief    : Self-checking bench for simon_sequencer with an LFSR/sequence model.
// Revision : 1.0
// ============================================================================
module tb_simon_sequencer;

    localparam int ON  = 4;
    localparam int OFF = 2;
    localparam int TMO = 20;
    localparam int ML  = 3;

    logic       clk_d = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] btn   = 4'h0;
    logic [3:0] led;
    logic [5:0] level;
    logic       busy;
    logic       game_over;
    logic       win;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] tb_lfsr;
    logic [1:0]  seq [$];
    int          lvl = 0;

    simon_sequencer #(
        .MAX_LEN      (ML),
        .ON_TICKS     (ON),
        .OFF_TICKS    (OFF),
        .TIMEOUT_TICKS(TMO),
        .SEED         (16'hACE1)
    ) dut (
        .clk_d    (clk_d),
        .rst_n    (rst_n),
        .start    (start),
        .btn      (btn),
        .led      (led),
        .level    (level),
        .busy     (busy),
        .game_over(game_over),
        .win      (win)
    );

    always #5 clk_d = ~clk_d;

    // Taps at bits 0,2,3,5 of a right-shifting register
    always @(posedge clk_d or negedge rst_n) begin
        if (!rst_n) tb_lfsr <= 16'hACE1;
        else        tb_lfsr <= {^(tb_lfsr & 16'h002D), tb_lfsr[15:1]};
    end

    function automatic logic [3:0] oh(input logic [1:0] c);
        return 4'b0001 << c;
    endfunction

    function automatic logic [12:0] pack(input logic [3:0] l, input int lv,
                                         input logic b, input logic g, input logic w);
        return {l, 6'(lv), b, g, w};
    endfunction

    function automatic logic [12:0] bv(input logic [3:0] l);
        return {l, 6'(lvl), 1'b1, 1'b0, 1'b0};
    endfunction

    task automatic step();
        @(negedge clk_d);
    endtask

    task automatic check(input string tag, input logic [12:0] exp);
        n_tests++;
        assert ({led, level, busy, game_over, win} === exp)
        else begin
            n_fail++;
            $error("FAIL %s: led/level/busy/game_over/win observed %b/%0d/%b/%b/%b expected %b/%0d/%b/%b/%b",
                   tag, led, level, busy, game_over, win,
                   exp[12:9], exp[8:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic noise();
        btn   = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
        start = ($urandom_range(0, 4) == 0);
    endtask

    // Entered at the GEN cycle; leaves at the first WAIT_IN cycle
    task automatic playback();
        check("gen", bv(4'h0));
        seq.push_back(tb_lfsr[1:0]);
        lvl++;
        noise();
        for (int c = 0; c < OFF; c++) begin
            step(); check("pre", bv(4'h0)); noise();
        end
        for (int i = 0; i < lvl; i++) begin
            for (int c = 0; c < ON; c++) begin
                step(); check("show_on", bv(oh(seq[i]))); noise();
            end
            for (int c = 0; c < OFF; c++) begin
                step(); check("show_off", bv(4'h0)); noise();
            end
        end
        step(); btn = 4'h0; start = 1'b0;
        check("wait_in", bv(4'h0));
    endtask

    task automatic press(input logic [3:0] b, input int d);
        for (int k = 0; k < d; k++) begin
            btn = 4'h0; start = ($urandom_range(0, 3) == 0);
            step(); check("wait_hold", bv(4'h0));
        end
        btn = b; start = ($urandom_range(0, 3) == 0);
        step(); btn = 4'h0; start = 1'b0;
    endtask

    task automatic echo(input logic [3:0] b);
        for (int c = 0; c < ON; c++) begin
            if (c != 0) step();
            check("echo", bv(b)); noise();
        end
        step(); btn = 4'h0; start = 1'b0;
    endtask

    task automatic timeout_wait();
        for (int k = 0; k < TMO - 1; k++) begin
            btn = 4'h0; start = ($urandom_range(0, 3) == 0);
            step(); check("wait_hold", bv(4'h0));
        end
        btn = 4'h0; start = 1'b0;
        step();
    endtask

    task automatic new_game();
        start = 1'b1; btn = 4'($urandom_range(0, 15));
        step(); start = 1'b0; btn = 4'h0;
        seq.delete(); lvl = 0;
    endtask

    initial begin
        logic [1:0] col;
        logic [1:0] wc;

        repeat (3) step();
        check("reset", pack(4'h0, 0, 1'b0, 1'b0, 1'b0));
        rst_n = 1'b1;
        repeat ($urandom_range(1, 30)) begin
            btn = 4'($urandom_range(0, 15));
            step(); check("idle", pack(4'h0, 0, 1'b0, 1'b0, 1'b0));
        end

        // Full game to WIN with random entry delays
        new_game();
        for (int L = 1; L <= ML; L++) begin
            playback();
            for (int i = 0; i < L; i++) begin
                press(oh(seq[i]), $urandom_range(0, TMO - 1));
                echo(oh(seq[i]));
                if (i < L - 1) check("wait_next", bv(4'h0));
            end
        end
        for (int n = 0; n < 3 * ON; n++) begin
            check("win", pack(((n / ON) % 2 == 0) ? 4'b0101 : 4'b1010, lvl, 1'b0, 1'b0, 1'b1));
            btn = 4'($urandom_range(0, 15));
            step();
        end

        // Latest legal press, then multi-hot press at level 2
        new_game();
        playback();
        press(oh(seq[0]), TMO - 1);
        echo(oh(seq[0]));
        playback();
        press(4'b0011, $urandom_range(0, TMO - 1));
        check("fail_multi", pack(4'hF, 2, 1'b0, 1'b1, 1'b0));
        repeat (5) begin
            btn = 4'($urandom_range(0, 15));
            step(); check("fail_hold", pack(4'hF, 2, 1'b0, 1'b1, 1'b0));
        end

        // Restart from FAIL, then timeout on the second entry of level 2
        new_game();
        playback();
        press(oh(seq[0]), $urandom_range(0, TMO - 1));
        echo(oh(seq[0]));
        playback();
        press(oh(seq[0]), $urandom_range(0, TMO - 1));
        echo(oh(seq[0]));
        check("wait_second", bv(4'h0));
        timeout_wait();
        check("fail_timeout", pack(4'hF, 2, 1'b0, 1'b1, 1'b0));

        // Wrong single colour at level 1
        new_game();
        playback();
        wc = seq[0] + 2'($urandom_range(1, 3));
        press(oh(wc), $urandom_range(0, TMO - 1));
        check("fail_wrong", pack(4'hF, 1, 1'b0, 1'b1, 1'b0));

        // Asynchronous reset in the middle of SHOW_ON
        new_game();
        check("gen_rst", bv(4'h0));
        col = tb_lfsr[1:0];
        lvl = 1;
        repeat (OFF + 2) step();
        check("show_before_rst", bv(oh(col)));
        #1 rst_n = 1'b0;
        #1 check("async_rst", pack(4'h0, 0, 1'b0, 1'b0, 1'b0));
        step();
        rst_n = 1'b1;
        repeat (10) begin
            btn = 4'($urandom_range(0, 15));
            step(); check("idle_after_rst", pack(4'h0, 0, 1'b0, 1'b0, 1'b0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/simon_sequencer.md
Name: simon_sequencer

Overview:
- Game controller for the Simon Says display path: builds a random colour sequence, plays it back on the four box-highlight lines (blue, green, yellow, red), then checks the player's button entries.
- Its led[3:0] output drives the pixel generator's LED0..LED3 inputs directly: bit 0 is blue, bit 1 green, bit 2 yellow, bit 3 red.
- Runs in the pixel clock domain. Buttons arrive already debounced and synchronised as one-cycle pulses.

Parameters:
- MAX_LEN, 16: sequence length needed to win (2..32).
- ON_TICKS, 12500000: cycles a playback or echo LED stays lit.
- OFF_TICKS, 6250000: dark gap between playback steps, and before playback begins.
- TIMEOUT_TICKS, 125000000: cycles allowed per player entry before a fail.
- SEED, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- clk_d, input, 1: pixel clock; all state updates on its rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: one-cycle pulse that begins a new game.
- btn, input, 4: one-cycle press pulses, using the same bit order as led.
- led, output, 4: box highlight lines to the pixel generator.
- level, output, 6: current sequence length, 0..MAX_LEN.
- busy, output, 1: high in every state except IDLE, FAIL and WIN.
- game_over, output, 1: high while in FAIL.
- win, output, 1: high while in WIN.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; led=0, level=0, busy=0, game_over=0, win=0.
  - LFSR=SEED; tick counter=0; sequence memory contents are don't-care.
- LFSR:
  - 16-bit Fibonacci, x^16+x^14+x^13+x^11+1.
  - Steps every cycle, including in IDLE.
  - New step colour = lfsr[1:0] in the GEN cycle.
- Sequence memory: MAX_LEN x 2 bits; index register idx has width clog2(MAX_LEN)+1.
- One shared tick counter. It clears on every state entry, and a timed state exits when tick == N-1, so the state lasts exactly N cycles.
- States and transitions:
  - IDLE: led=0. On start: level←0, go to GEN.
  - GEN (1 cycle): mem[level]←lfsr[1:0]; level←level+1; idx←0; go to PRE.
  - PRE: led=0 for OFF_TICKS, then go to SHOW_ON.
  - SHOW_ON: led=onehot(mem[idx]) for ON_TICKS, then go to SHOW_OFF.
  - SHOW_OFF: led=0 for OFF_TICKS.
    - If idx+1 < level: idx←idx+1, go to SHOW_ON.
    - Otherwise: idx←0, go to WAIT_IN.
  - WAIT_IN: led=0.
    - btn==0: keep counting. When the count reaches TIMEOUT_TICKS, go to FAIL.
    - btn==onehot(mem[idx]): go to ECHO.
    - Any other nonzero btn, including multi-hot, counts as a wrong press: go to FAIL.
  - ECHO: led=the pressed one-hot for ON_TICKS, then:
    - idx+1 < level: idx←idx+1, go to WAIT_IN (timeout restarts).
    - level == MAX_LEN: go to WIN.
    - Otherwise: go to GEN.
  - FAIL: led=4'b1111, game_over=1, level holds. On start, go to GEN with level←0.
  - WIN: win=1; led alternates 4'b0101 / 4'b1010, toggling every ON_TICKS and starting with 0101. On start, go to GEN with level←0.
- Input qualification:
  - btn outside WAIT_IN is ignored; ECHO does not queue presses.
  - start is ignored while busy=1.
  - A start and a btn pulse in the same cycle: start wins only in IDLE, FAIL or WIN.
- Output timing: all outputs are registered and reflect the current state from the first cycle of that state.
- Reset mid-operation: an immediate asynchronous return to IDLE; the game does not resume.

Test Plan:
- Bench parameters for all scenarios: ON=4, OFF=2, TIMEOUT=20, MAX_LEN=3, SEED=16'hACE1. The bench models the LFSR to predict colours.
- Reset/idle: assert rst_n=0 mid-SHOW_ON → led=0, level=0, busy=0 in the same cycle (asynchronous). Release and hold 10 cycles → no change.
- Start/playback: start pulse → GEN 1 cycle, then led=0 for 2 cycles, then led=predicted one-hot for exactly 4 cycles, then 0 for 2 cycles, then WAIT_IN with level=1 and busy=1.
- Full win: enter the correct colour at each level → each echo lasts 4 cycles and level steps 1→2→3. After the third correct entry of level 3: win=1, led=0101 for 4 cycles, then 1010.
- Wrong/multi-hot press: in WAIT_IN at level 2, press btn=4'b0011 → next cycle game_over=1, led=1111, level=2. Then start → level=1, game_over=0.
- Timeout: no press for 20 cycles in WAIT_IN → FAIL. A correct press at cycle 19 → ECHO, not FAIL.
- Ignored inputs: btn pulses during SHOW_ON/SHOW_OFF/ECHO and start during WAIT_IN → no state change; the playback sequence and level are unchanged.
